// File: rtl/pwm_breathe_multi.sv
// pwm_breathe_multi: multi-channel breathing LED driver with shared PWM carrier and triangle phase sweep
// Optional GAMMA_EN macro squares the latched duty for a perceptually smoother ramp.
module pwm_breathe_multi #(
  parameter int CH           = 4,
  parameter int CW           = 8,
  parameter int PERIOD       = 30,
  parameter int STEP_DIV     = 300,
  parameter int PHASE_SPREAD = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          hold,
  output logic [CH-1:0] led,
  output logic          period_tick,
  output logic [CW:0]   phase
);
  localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam int W2 = 2*CW+2;
  localparam logic [CW:0]   L_PER = (CW+1)'(PERIOD);
  localparam logic [CW:0]   L_P2W = (CW+1)'(2*PERIOD);
  localparam logic [CW+1:0] L_P2  = (CW+2)'(2*PERIOD);
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_div;
  logic [CW:0]   r_ph;
  logic          r_tick;
  logic          w_wrap, w_step;
  logic [CW:0]   w_ph_nx, w_src;
  always_comb begin
    w_wrap  = en && r_cnt == CW'(PERIOD-1);
    w_step  = w_wrap && !hold && r_div == DW'(STEP_DIV-1);
    w_ph_nx = w_step ? (r_ph == L_P2W - 1'b1 ? '0 : r_ph + 1'b1) : r_ph;
    w_src   = rst ? '0 : w_ph_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_div  <= '0;
      r_ph   <= '0;
      r_tick <= 1'b0;
    end else if (en) begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
      if (w_wrap && !hold) r_div <= r_div == DW'(STEP_DIV-1) ? '0 : r_div + 1'b1;
      r_ph   <= w_ph_nx;
    end else begin
      r_tick <= 1'b0;
    end
  end
  for (genvar g = 0; g < CH; g++) begin : g_ch
    localparam logic [CW+1:0] OFS = PHASE_SPREAD != 0 ? (CW+2)'((g*2*PERIOD)/CH) : '0;
    logic [CW+1:0] w_s;
    logic [CW:0]   w_p, w_t, w_d;
    logic [CW:0]   r_duty;
    always_comb begin
      w_s = {1'b0, w_src} + OFS;
      w_p = w_s >= L_P2 ? (CW+1)'(w_s - L_P2) : w_s[CW:0];
      w_t = w_p <= L_PER ? w_p : L_P2W - w_p;
`ifdef GAMMA_EN
      w_d = (CW+1)'((W2'(w_t) * W2'(w_t)) / W2'(PERIOD));
`else
      w_d = w_t;
`endif
    end
    // duty only moves at reset or a carrier boundary, so every period is glitch-free
    always_ff @(posedge clk) begin
      if (rst || w_wrap) r_duty <= w_d;
    end
    assign led[g] = en & ({1'b0, r_cnt} < r_duty);
  end
  assign period_tick = r_tick;
  assign phase       = r_ph;
endmodule

// File: tb/tb_pwm_breathe_multi.sv
// tb_pwm_breathe_multi: table vectors, corner sequences and randomized run against a period-count model
module tb_pwm_breathe_multi;
  localparam int CH = 2, CW = 3, P = 4, SD = 2;
  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, hold = 1'b0;
  logic [CH-1:0] led;
  logic          period_tick;
  logic [CW:0]   phase;
  pwm_breathe_multi #(.CH(CH), .CW(CW), .PERIOD(P), .STEP_DIV(SD), .PHASE_SPREAD(1)) dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold),
    .led(led), .period_tick(period_tick), .phase(phase)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int m_t = 0, m_n = 0;
  bit m_tick = 1'b0;
  // model: enabled clocks since reset and non-held period boundaries fully determine the state
  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_n = 0; m_tick = 1'b0;
    end else if (en) begin
      m_tick = (m_t % P) == P-1;
      if (m_tick && !hold) m_n++;
      m_t++;
    end else begin
      m_tick = 1'b0;
    end
  end
  function automatic int mph();
    return (m_n / SD) % (2*P);
  endfunction
  function automatic int mduty(input int ph, input int i);
    int p, t;
    p = (ph + (i*2*P)/CH) % (2*P);
    t = p <= P ? p : 2*P - p;
`ifdef GAMMA_EN
    return t*t/P;
`else
    return t;
`endif
  endfunction
  function automatic logic [CH-1:0] mled();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = en && ((m_t % P) < mduty(mph(), i));
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cmp_all();
    chk("led", 32'(led), 32'(mled()));
    chk("tick", 32'(period_tick), 32'(m_tick));
    chk("phase", 32'(phase), 32'(mph()));
  endtask
  task automatic cyc(input bit r, input bit e, input bit h);
    @(negedge clk);
    rst = r; en = e; hold = h;
    #1;
    cmp_all();
  endtask
  typedef struct {
    bit r, e, h;
    logic [CH-1:0] led;
    bit tick;
    int ph;
  } vec_t;
  vec_t vt[13];
  initial begin
    int ticks;
    bit hit;
    for (int k = 0; k < 13; k++) begin
      vt[k].r = 1'b0; vt[k].e = 1'b1; vt[k].h = 1'b0;
      vt[k].tick = k > 0 && k % 4 == 0;
      vt[k].ph = k >= 8 ? 1 : 0;
`ifdef GAMMA_EN
      vt[k].led = k < 8 ? 2'b10 : (k % 4 < 2 ? 2'b10 : 2'b00);
`else
      vt[k].led = k < 8 ? 2'b10 : (k % 4 == 0 ? 2'b11 : (k % 4 == 3 ? 2'b00 : 2'b10));
`endif
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_led", 32'(led), 0);
    chk("rst_tick", 32'(period_tick), 0);
    chk("rst_phase", 32'(phase), 0);
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      rst = vt[k].r; en = vt[k].e; hold = vt[k].h;
      #1;
      chk($sformatf("vec%0d_led", k), 32'(led), 32'(vt[k].led));
      chk($sformatf("vec%0d_tick", k), 32'(period_tick), 32'(vt[k].tick));
      chk($sformatf("vec%0d_phase", k), 32'(phase), 32'(vt[k].ph));
    end
    cyc(1, 0, 0);
    for (int k = 0; k < 256; k++) cyc(0, 1, 0);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      cyc(0, 1, 0);
      hit = m_t % P == 0 && mph() == 3;
    end
    chk("wait_ph3", 32'(hit), 1);
    ticks = 0;
    for (int k = 0; k < 20*P; k++) begin
      cyc(0, 1, 1);
      ticks += int'(period_tick);
      chk("hold_phase", 32'(phase), 3);
    end
    chk("hold_ticks", 32'(ticks), 20);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    chk("dis_led", 32'(led), 0);
    cyc(0, 0, 1);
    chk("dis_tick", 32'(period_tick), 0);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      cyc(0, 1, 0);
      hit = m_t % P == 2 && mph() == 5;
    end
    chk("wait_ph5", 32'(hit), 1);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    chk("rst_mid_phase", 32'(phase), 0);
    chk("rst_mid_tick", 32'(period_tick), 0);
    chk("rst_mid_led", 32'(led), 32'(2'b10));
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
